pipelined_adder: RTL and testbench



---
 rtl/adder_pkg.sv | 16 +
 rtl/seg_adder.sv | 27 ++
 rtl/pipelined_adder.sv | 130 +++++++++++++
 tb/tb_pipelined_adder.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/adder_pkg.sv
// Shared constants and operation encoding for the skewed pipelined adder.
package adder_pkg;

  localparam int ADD_WIDTH_DEF = 16;
  localparam int ADD_SEG_DEF   = 4;

  typedef enum logic {
    OP_ADD = 1'b0,
    OP_SUB = 1'b1
  } op_e;

  function automatic int calc_nstages(input int width, input int seg);
    return (seg > 0) ? (width / seg) : 0;
  endfunction

endpackage

// File: rtl/seg_adder.sv
// Combinational SEG-bit ripple adder. It also exposes the carry into its MSB,
// which the last stage needs to compute signed overflow.
module seg_adder #(
  parameter int SEG = 4
) (
  input  logic [SEG-1:0] a_i,
  input  logic [SEG-1:0] b_i,
  input  logic           c_i,
  output logic [SEG-1:0] sum_o,
  output logic           cout_o,
  output logic           cmsb_o
);

  always_comb begin
    logic c;
    c      = c_i;
    sum_o  = '0;
    cmsb_o = c_i;
    for (int i = 0; i < SEG; i++) begin
      sum_o[i] = a_i[i] ^ b_i[i] ^ c;
      if (i == SEG - 1) cmsb_o = c;
      c = (a_i[i] & b_i[i]) | (c & (a_i[i] ^ b_i[i]));
    end
    cout_o = c;
  end

endmodule

// File: rtl/pipelined_adder.sv
// Skewed add/subtract pipeline: each stage adds one SEG-bit slice and carries
// the still-unprocessed upper operand bits forward, with a global stall enable.
module pipelined_adder
  import adder_pkg::*;
#(
  parameter int WIDTH = ADD_WIDTH_DEF,
  parameter int SEG   = ADD_SEG_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] S,
  output logic             Cout,
  output logic             V
);

  localparam int NSTAGES = calc_nstages(WIDTH, SEG);

  if (WIDTH < 1 || SEG < 1 || (WIDTH % SEG) != 0) begin : g_param_check
    $error("pipelined_adder: WIDTH must be >= 1 and an exact multiple of SEG");
  end

  op_e              op;
  logic             en;
  logic [WIDTH-1:0] b_eff;
  logic             c0;
  logic             out_valid_q;
  logic [WIDTH-1:0] s_q;
  logic             cout_q;
  logic             v_q;

  // Subtract is A + ~B + ~Cin, so Cout reads as "no borrow".
  assign op       = op_e'(sub);
  assign b_eff    = (op == OP_SUB) ? ~B : B;
  assign c0       = (op == OP_SUB) ? ~Cin : Cin;
  assign en       = !out_valid_q || out_ready;
  assign in_ready = en;

  for (genvar k = 0; k < NSTAGES; k++) begin : g_stage
    localparam int LO     = k * SEG;
    localparam int REM_IN = WIDTH - LO;

    logic [REM_IN-1:0] a_in;
    logic [REM_IN-1:0] b_in;
    logic              c_in;
    logic              valid_in;
    logic              valid_q;
    logic [SEG-1:0]    seg_sum;
    logic              seg_cout;
    logic              seg_cmsb;
    logic [LO+SEG-1:0] sum_next;

    if (k == 0) begin : g_src
      assign a_in     = A;
      assign b_in     = b_eff;
      assign c_in     = c0;
      assign valid_in = in_valid;
      assign sum_next = seg_sum;
    end else begin : g_src
      assign a_in     = g_stage[k-1].g_fwd.a_q;
      assign b_in     = g_stage[k-1].g_fwd.b_q;
      assign c_in     = g_stage[k-1].g_fwd.carry_q;
      assign valid_in = g_stage[k-1].valid_q;
      assign sum_next = {seg_sum, g_stage[k-1].g_fwd.sum_q};
    end

    seg_adder #(.SEG(SEG)) u_seg (
      .a_i    (a_in[SEG-1:0]),
      .b_i    (b_in[SEG-1:0]),
      .c_i    (c_in),
      .sum_o  (seg_sum),
      .cout_o (seg_cout),
      .cmsb_o (seg_cmsb)
    );

    always_ff @(posedge clk) begin
      if (rst) begin
        valid_q <= 1'b0;
      end else if (en) begin
        valid_q <= valid_in;
      end
    end

    if (k < NSTAGES - 1) begin : g_fwd
      localparam int REM_OUT = REM_IN - SEG;

      logic [REM_OUT-1:0] a_q;
      logic [REM_OUT-1:0] b_q;
      logic [LO+SEG-1:0]  sum_q;
      logic               carry_q;

      // Intermediate data is qualified by valid_q and needs no reset.
      always_ff @(posedge clk) begin
        if (en) begin
          a_q     <= a_in[REM_IN-1:SEG];
          b_q     <= b_in[REM_IN-1:SEG];
          sum_q   <= sum_next;
          carry_q <= seg_cout;
        end
      end
    end else begin : g_last
      always_ff @(posedge clk) begin
        if (rst) begin
          s_q    <= '0;
          cout_q <= 1'b0;
          v_q    <= 1'b0;
        end else if (en) begin
          s_q    <= sum_next;
          cout_q <= seg_cout;
          v_q    <= seg_cmsb ^ seg_cout;
        end
      end

      assign out_valid_q = valid_q;
    end
  end

  assign out_valid = out_valid_q;
  assign S         = s_q;
  assign Cout      = cout_q;
  assign V         = v_q;

endmodule

// File: tb/tb_pipelined_adder.sv
// Self-checking bench for pipelined_adder: directed corner cases, randomized
// traffic with backpressure against an arithmetic model, reset flush, 1-stage build.
module tb_pipelined_adder;
  import adder_pkg::*;

  localparam int NST = 4;

  typedef struct packed {
    logic [15:0] s;
    logic        c;
    logic        v;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [15:0] A, B, S;
  logic        Cin, sub, Cout, V;

  logic        in_valid_5, in_ready_5, out_valid_5, out_ready_5;
  logic [4:0]  A_5, B_5, S_5;
  logic        Cin_5, sub_5, Cout_5, V_5;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  pipelined_adder #(.WIDTH(16), .SEG(4)) u_dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .B(B), .Cin(Cin), .sub(sub),
    .out_valid(out_valid), .out_ready(out_ready),
    .S(S), .Cout(Cout), .V(V)
  );

  pipelined_adder #(.WIDTH(5), .SEG(5)) u_dut5 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid_5), .in_ready(in_ready_5),
    .A(A_5), .B(B_5), .Cin(Cin_5), .sub(sub_5),
    .out_valid(out_valid_5), .out_ready(out_ready_5),
    .S(S_5), .Cout(Cout_5), .V(V_5)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Plain integer arithmetic: subtract is A - B - Cin, Cout = no borrow,
  // V = true signed result outside the 16-bit signed range.
  function automatic exp_t model(input logic [15:0] a, input logic [15:0] b,
                                 input logic ci, input logic op_sub);
    exp_t e;
    int ua, ub, sa, sbv, c, r_u, r_s;
    ua  = int'(a);
    ub  = int'(b);
    sa  = $signed(a);
    sbv = $signed(b);
    c   = ci ? 1 : 0;
    if (!op_sub) begin
      r_u = ua + ub + c;
      r_s = sa + sbv + c;
      e.c = (r_u > 65535);
    end else begin
      r_u = ua - ub - c;
      r_s = sa - sbv - c;
      e.c = (ua >= ub + c);
    end
    e.s = r_u[15:0];
    e.v = (r_s > 32767) || (r_s < -32768);
    return e;
  endfunction

  task automatic run_one(input string tag, input logic [15:0] a, input logic [15:0] b,
                         input logic ci, input logic op_sub,
                         input logic [15:0] exp_s, input logic exp_c, input logic exp_v);
    int lat;
    A = a; B = b; Cin = ci; sub = op_sub;
    in_valid = 1'b1; out_ready = 1'b1;
    #1;
    check({tag, "_in_ready"}, in_ready, 1'b1);
    tick();
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 12) begin
      tick();
      lat++;
    end
    check({tag, "_latency"}, lat, NST);
    check({tag, "_S"}, S, exp_s);
    check({tag, "_Cout"}, Cout, exp_c);
    check({tag, "_V"}, V, exp_v);
    tick();
    check({tag, "_no_dup"}, out_valid, 1'b0);
  endtask

  // Outputs are compared with the scoreboard head on every valid cycle,
  // so a stalled result must also stay put.
  task automatic rand_phase(input string tag, input int nops, input bit bubbles);
    exp_t q[$];
    exp_t e;
    int sent = 0;
    int got  = 0;
    int cyc  = 0;
    while (got < nops && cyc < 400) begin
      out_ready = 1'($urandom_range(0, 1));
      in_valid  = (sent < nops) && (!bubbles || ($urandom_range(0, 2) != 0));
      A   = 16'($urandom);
      B   = 16'($urandom);
      Cin = 1'($urandom_range(0, 1));
      sub = 1'($urandom_range(0, 1));
      #1;
      if (out_valid) begin
        if (q.size() == 0) begin
          check({tag, "_spurious"}, out_valid, 1'b0);
        end else begin
          check({tag, "_S"}, S, q[0].s);
          check({tag, "_Cout"}, Cout, q[0].c);
          check({tag, "_V"}, V, q[0].v);
          if (out_ready) begin
            void'(q.pop_front());
            got++;
          end
        end
      end
      if (in_valid && in_ready) begin
        e = model(A, B, Cin, sub);
        q.push_back(e);
        sent++;
      end
      tick();
      cyc++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    check({tag, "_count"}, got, nops);
    check({tag, "_leftover"}, q.size(), 0);
    check({tag, "_drained"}, out_valid, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    in_valid = 1'b1; out_ready = 1'b1;
    A = 16'h1234; B = 16'h1111; Cin = 1'b0; sub = 1'b0;
    in_valid_5 = 1'b1; out_ready_5 = 1'b1;
    A_5 = 5'd3; B_5 = 5'd4; Cin_5 = 1'b0; sub_5 = 1'b0;
    repeat (2) tick();
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_S", S, 16'h0000);
    check("rst_Cout", Cout, 1'b0);
    check("rst_V", V, 1'b0);
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_out_valid_5", out_valid_5, 1'b0);

    rst = 1'b0; in_valid = 1'b0; in_valid_5 = 1'b0;
    repeat (6) tick();
    check("rst_in_valid_dropped", out_valid, 1'b0);

    run_one("wrap_ffff", 16'hFFFF, 16'h0001, 1'b0, OP_ADD, 16'h0000, 1'b1, 1'b0);
    run_one("ovf_7fff",  16'h7FFF, 16'h0001, 1'b0, OP_ADD, 16'h8000, 1'b0, 1'b1);
    run_one("sub_5m7",   16'h0005, 16'h0007, 1'b0, OP_SUB, 16'hFFFE, 1'b0, 1'b0);
    run_one("sub_cin",   16'h8000, 16'h0001, 1'b1, OP_SUB, 16'h7FFE, 1'b1, 1'b1);
    run_one("add_cin",   16'h00FF, 16'h0F00, 1'b1, OP_ADD, 16'h1000, 1'b0, 1'b0);

    rand_phase("b2b", 8, 1'b0);
    rand_phase("bubbles", 12, 1'b1);

    out_ready = 1'b1; sub = 1'b0; Cin = 1'b0;
    A = 16'h1111; B = 16'h2222; in_valid = 1'b1;
    tick();
    A = 16'h3333; B = 16'h4444;
    tick();
    rst = 1'b1; A = 16'h5555; B = 16'h6666;
    #1;
    check("midrst_in_ready", in_ready, 1'b1);
    tick();
    rst = 1'b0; in_valid = 1'b0;
    check("midrst_out_valid", out_valid, 1'b0);
    check("midrst_S", S, 16'h0000);
    check("midrst_Cout", Cout, 1'b0);
    check("midrst_V", V, 1'b0);
    for (int i = 0; i < 8; i++) begin
      tick();
      check("midrst_no_result", out_valid, 1'b0);
    end

    A_5 = 5'd31; B_5 = 5'd1; Cin_5 = 1'b1; sub_5 = 1'b0;
    in_valid_5 = 1'b1; out_ready_5 = 1'b1;
    #1;
    check("w5_in_ready", in_ready_5, 1'b1);
    tick();
    in_valid_5 = 1'b0;
    check("w5_latency1", out_valid_5, 1'b1);
    check("w5_S", S_5, 5'd1);
    check("w5_Cout", Cout_5, 1'b1);
    check("w5_V", V_5, 1'b0);
    tick();
    check("w5_no_dup", out_valid_5, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
